// File: rtl/sn_mult_scheduler.sv
// Shares one stochastic-multiplier datapath between two requesters: arbitrate, load, run a 2^w window, drain, respond.
// Build option SN_SCHED_RR_EN: round-robin tie-break via prio_ptr; otherwise requester 0 wins ties.
module sn_mult_scheduler #(
   parameter int unsigned WIDTH    = 9,
   parameter int unsigned CNT_W    = 17,
   parameter int unsigned PIPE_LAT = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req0_valid,
   input  logic [WIDTH-1:0] req0_a,
   input  logic [WIDTH-1:0] req0_b,
   output logic             req0_ready,
   input  logic             req1_valid,
   input  logic [WIDTH-1:0] req1_a,
   input  logic [WIDTH-1:0] req1_b,
   output logic             req1_ready,
   input  logic [4:0]       win_log2,
   output logic             dp_clear,
   output logic             dp_run,
   output logic [WIDTH-1:0] dp_op_a,
   output logic [WIDTH-1:0] dp_op_b,
   input  logic [CNT_W:0]   dp_count,
   output logic             rsp_valid,
   output logic             rsp_id,
   output logic [WIDTH-1:0] rsp_result,
   input  logic             rsp_ready,
   output logic             busy
);
   localparam int unsigned CW    = CNT_W + 1;
   localparam int unsigned DW    = $clog2(PIPE_LAT + 2);
   localparam logic [4:0]  W_MIN = 5'(WIDTH);
   localparam logic [4:0]  W_MAX = 5'(CNT_W);

   typedef enum logic [2:0] {S_IDLE, S_LOAD, S_RUN, S_DRAIN, S_RESP} state_t;

   state_t           r_state;
   state_t           w_next;
   logic             r_arm;
   logic             r_id;
   logic [4:0]       r_w_eff;
   logic [WIDTH-1:0] r_op_a;
   logic [WIDTH-1:0] r_op_b;
   logic [CW-1:0]    r_win_cnt;
   logic [DW-1:0]    r_drn_cnt;
   logic [WIDTH-1:0] r_result;

   logic             w_prio;
   logic             w_gnt_id;
   logic             w_grant;
   logic [4:0]       w_w_eff;
   logic [4:0]       w_shamt;
   logic [CW-1:0]    w_full;
   logic             w_last_run;
   logic             w_last_drain;
   logic [WIDTH-1:0] w_scaled;

`ifdef SN_SCHED_RR_EN
   logic r_prio_ptr;

   // Tie-break pointer flips away from whoever was just served.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_prio_ptr <= 1'b0;
      else if (w_grant)
         r_prio_ptr <= ~w_gnt_id;
   end

   assign w_prio = r_prio_ptr;
`else
   assign w_prio = 1'b0;
`endif

   // r_arm keeps grants off while reset is held and for the first cycle after release.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_arm <= 1'b0;
      else
         r_arm <= 1'b1;
   end

   always_comb begin
      w_gnt_id = 1'b0;
      if (req0_valid && req1_valid)
         w_gnt_id = w_prio;
      else if (req1_valid)
         w_gnt_id = 1'b1;
   end

   assign w_grant = r_arm && (r_state == S_IDLE) && (req0_valid || req1_valid);

   always_comb begin
      w_w_eff = win_log2;
      if (win_log2 < W_MIN)
         w_w_eff = W_MIN;
      else if (win_log2 > W_MAX)
         w_w_eff = W_MAX;
   end

   assign w_full       = CW'(1) << r_w_eff;
   assign w_last_run   = (r_win_cnt == (w_full - CW'(1)));
   assign w_last_drain = (r_drn_cnt == DW'(PIPE_LAT - 1));
   assign w_shamt      = r_w_eff - W_MIN;
   assign w_scaled     = (dp_count == w_full) ? {WIDTH{1'b1}} : WIDTH'(dp_count >> w_shamt);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_state <= S_IDLE;
      else
         r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (w_grant) w_next = S_LOAD;
         S_LOAD:  w_next = S_RUN;
         S_RUN: begin
            if (w_last_run) begin
               if (PIPE_LAT == 0)
                  w_next = S_RESP;
               else
                  w_next = S_DRAIN;
            end
         end
         S_DRAIN: if (w_last_drain) w_next = S_RESP;
         S_RESP:  if (rsp_ready) w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_comb begin
      req0_ready = 1'b0;
      req1_ready = 1'b0;
      dp_clear   = 1'b0;
      dp_run     = 1'b0;
      rsp_valid  = 1'b0;
      busy       = (r_state != S_IDLE);
      case (r_state)
         S_IDLE: begin
            req0_ready = w_grant && !w_gnt_id;
            req1_ready = w_grant && w_gnt_id;
         end
         S_LOAD:         dp_clear  = 1'b1;
         S_RUN, S_DRAIN: dp_run    = 1'b1;
         S_RESP:         rsp_valid = 1'b1;
         default: ;
      endcase
   end

   // Job context, window/drain counters and the result captured on entry to RESP.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_id      <= 1'b0;
         r_w_eff   <= W_MIN;
         r_op_a    <= '0;
         r_op_b    <= '0;
         r_win_cnt <= '0;
         r_drn_cnt <= '0;
         r_result  <= '0;
      end else begin
         if (w_grant) begin
            r_id    <= w_gnt_id;
            r_w_eff <= w_w_eff;
            r_op_a  <= w_gnt_id ? req1_a : req0_a;
            r_op_b  <= w_gnt_id ? req1_b : req0_b;
         end
         if (r_state == S_LOAD)
            r_win_cnt <= '0;
         else if (r_state == S_RUN)
            r_win_cnt <= r_win_cnt + CW'(1);
         if (r_state == S_RUN)
            r_drn_cnt <= '0;
         else if (r_state == S_DRAIN)
            r_drn_cnt <= r_drn_cnt + DW'(1);
         if ((w_next == S_RESP) && (r_state != S_RESP))
            r_result <= w_scaled;
      end
   end

   assign dp_op_a    = r_op_a;
   assign dp_op_b    = r_op_b;
   assign rsp_id     = r_id;
   assign rsp_result = r_result;

endmodule

// File: tb/tb_sn_mult_scheduler.sv
// Bench for sn_mult_scheduler: directed and randomised jobs checked against a job-level timing/result model.
`timescale 1ns/1ps
module tb_sn_mult_scheduler;
   localparam int WIDTH    = 9;
   localparam int CNT_W    = 17;
   localparam int PIPE_LAT = 2;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             req0_valid, req1_valid;
   logic [WIDTH-1:0] req0_a, req0_b, req1_a, req1_b;
   logic             req0_ready, req1_ready;
   logic [4:0]       win_log2;
   logic             dp_clear, dp_run;
   logic [WIDTH-1:0] dp_op_a, dp_op_b;
   logic [CNT_W:0]   dp_count;
   logic             rsp_valid, rsp_id, rsp_ready, busy;
   logic [WIDTH-1:0] rsp_result;

   int n_checks = 0;
   int n_fail   = 0;
   int tb_ptr   = 0;

   sn_mult_scheduler #(.WIDTH(WIDTH), .CNT_W(CNT_W), .PIPE_LAT(PIPE_LAT)) dut (
      .clk(clk), .rst_n(rst_n),
      .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_ready(req0_ready),
      .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_ready(req1_ready),
      .win_log2(win_log2), .dp_clear(dp_clear), .dp_run(dp_run),
      .dp_op_a(dp_op_a), .dp_op_b(dp_op_b), .dp_count(dp_count),
      .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_result(rsp_result),
      .rsp_ready(rsp_ready), .busy(busy)
   );

   always #5 clk = ~clk;

   initial begin
      #3ms;
      $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
      $fatal(1);
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic int weff_of(input int w);
      if (w < WIDTH) return WIDTH;
      if (w > CNT_W) return CNT_W;
      return w;
   endfunction

   // Result rule: full window of ones saturates, otherwise keep the top WIDTH bits of the count.
   function automatic logic [WIDTH-1:0] model_result(input int w_eff, input int cnt);
      if (cnt == (1 << w_eff)) return {WIDTH{1'b1}};
      return WIDTH'(cnt >> (w_eff - WIDTH));
   endfunction

   function automatic int pick(input logic v0, input logic v1);
      if (v0 && v1) begin
`ifdef SN_SCHED_RR_EN
         return tb_ptr;
`else
         return 0;
`endif
      end
      if (v1) return 1;
      return 0;
   endfunction

   task automatic check_reset(input string tag);
      check({tag, "_ctrl"}, 32'({req0_ready, req1_ready, dp_clear, dp_run, rsp_valid, rsp_id, busy}), 32'd0);
      check({tag, "_ops"}, 32'({dp_op_a, dp_op_b}), 32'd0);
      check({tag, "_result"}, 32'(rsp_result), 32'd0);
   endtask

   // One full job from the grant cycle through the response handshake.
   task automatic do_job(input int cnt, input int rsp_delay);
      int id, weff, k, runs, lat;
      logic bad_clear, bad_ready, timeout, bad_stall;
      logic [WIDTH-1:0] ea, eb, exp_res;
      weff    = weff_of(int'(win_log2));
      id      = pick(req0_valid, req1_valid);
      ea      = (id == 1) ? req1_a : req0_a;
      eb      = (id == 1) ? req1_b : req0_b;
      exp_res = model_result(weff, cnt);
      lat     = 2 + (1 << weff) + PIPE_LAT;
      dp_count = (CNT_W+1)'(cnt);
      #1;
      check("grant_ready", 32'({req1_ready, req0_ready}), (id == 1) ? 32'd2 : 32'd1);
      tb_ptr = 1 - id;
      tick();
      win_log2 = 5'($urandom_range(0, 31));
      check("clear_cycle", 32'({dp_clear, dp_run, busy}), 32'b101);
      check("op_a", 32'(dp_op_a), 32'(ea));
      check("op_b", 32'(dp_op_b), 32'(eb));
      runs = 0; bad_clear = 1'b0; bad_ready = 1'b0; timeout = 1'b1;
      for (k = 2; k < lat + 20; k++) begin
         tick();
         if (rsp_valid) begin
            timeout = 1'b0;
            break;
         end
         if (dp_run) runs++;
         if (dp_clear) bad_clear = 1'b1;
         if (req0_ready || req1_ready || !busy) bad_ready = 1'b1;
      end
      check("rsp_timeout", 32'(timeout), 32'd0);
      check("rsp_latency", 32'(k), 32'(lat));
      check("run_cycles", 32'(runs), 32'((1 << weff) + PIPE_LAT));
      check("no_extra_clear_or_grant", 32'({bad_clear, bad_ready}), 32'd0);
      check("rsp_id", 32'(rsp_id), 32'(id));
      check("rsp_result", 32'(rsp_result), 32'(exp_res));
      check("run_off_at_rsp", 32'(dp_run), 32'd0);
      bad_stall = 1'b0;
      for (int s = 0; s < rsp_delay; s++) begin
         tick();
         if (!rsp_valid || rsp_result !== exp_res || rsp_id !== 1'(id) || !busy ||
             req0_ready || req1_ready || dp_run || dp_clear)
            bad_stall = 1'b1;
      end
      if (rsp_delay > 0) check("rsp_stall_stable", 32'(bad_stall), 32'd0);
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      check("idle_after_handshake", 32'({busy, rsp_valid}), 32'd0);
   endtask

   initial begin
      int w, we, cnt;
      logic [1:0] v;
      logic bad;
      rst_n = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0;
      req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
      win_log2 = 5'd9; dp_count = '0; rsp_ready = 1'b0;
      repeat (3) tick();
      req0_valid = 1'b1;
      #1;
      check_reset("por");
      req0_valid = 1'b0;
      rst_n = 1'b1;
      tick(); tick();

      // Saturation: full window of ones.
      req0_valid = 1'b1; req0_a = 9'h1FF; req0_b = 9'h1FF; win_log2 = 5'd9;
      do_job(512, 0);

      // Requester 1 alone, window clamped up to WIDTH, response stalled.
      req0_valid = 1'b0; req1_valid = 1'b1;
      req1_a = 9'($urandom); req1_b = 9'($urandom); win_log2 = 5'd3;
      do_job(int'($urandom_range(0, 511)), 10);

      // Scaling by a right shift of one.
      req1_valid = 1'b0; req0_valid = 1'b1;
      req0_a = 9'($urandom); req0_b = 9'($urandom); win_log2 = 5'd10;
      do_job(32'h180, 1);

      for (int r = 0; r < 5; r++) begin
         v = 2'($urandom_range(1, 3));
         req0_valid = v[0]; req1_valid = v[1];
         req0_a = 9'($urandom); req0_b = 9'($urandom);
         req1_a = 9'($urandom); req1_b = 9'($urandom);
         w = int'($urandom_range(0, 11));
         we = weff_of(w);
         win_log2 = 5'(w);
         cnt = ($urandom_range(0, 3) == 0) ? (1 << we) : int'($urandom_range(0, (1 << we) - 1));
         do_job(cnt, int'($urandom_range(0, 3)));
      end

      // Both requesters held valid: tie-break sequence.
      req0_valid = 1'b1; req1_valid = 1'b1;
      for (int r = 0; r < 4; r++) begin
         req0_a = 9'($urandom); req0_b = 9'($urandom);
         req1_a = 9'($urandom); req1_b = 9'($urandom);
         win_log2 = 5'd9;
         do_job(int'($urandom_range(0, 512)), 0);
      end

      // Large window (clamped to 2^CNT_W) aborted by reset mid-RUN.
      req1_valid = 1'b0; req0_valid = 1'b1; win_log2 = 5'd20;
      #1;
      check("big_grant", 32'({req1_ready, req0_ready}), 32'd1);
      tick(); tick();
      bad = 1'b0;
      for (int c = 0; c < 5000; c++) begin
         tick();
         if (!dp_run || rsp_valid || !busy || dp_clear) bad = 1'b1;
      end
      check("big_window_still_running", 32'(bad), 32'd0);
      #2;
      rst_n = 1'b0;
      #1;
      check_reset("mid_run_reset");
      tick(); tick();
      check_reset("mid_run_reset_held");
      rst_n = 1'b1;
      tb_ptr = 0;
      tick();
      win_log2 = 5'd9; req0_a = 9'($urandom); req0_b = 9'($urandom);
      do_job(int'($urandom_range(0, 511)), 2);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/sn_mult_scheduler.md
# sn_mult_scheduler

Controller that shares one stochastic-multiplier datapath (LFSR pair, comparators, XNOR, ones up-counter) between two requesters. It arbitrates operand-pair requests, loads the winning operands, clears and runs the datapath for a programmable 2^w-cycle window, waits out the datapath pipeline, and returns the scaled ones-count to the winner with a valid/ready response. It sits between the pin-level input deserialisers and the multiplier core.

## Interface
Parameters:
- WIDTH, 9, operand/result width (probability bits)
- CNT_W, 17, max log2 window length; datapath count is CNT_W+1 bits
- PIPE_LAT, 2, datapath register stages from dp_run to counted bit (comparator + XNOR)

Ports:
- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- req0_valid / req1_valid  in  1  requester has an operand pair
- req0_a, req0_b / req1_a, req1_b  in  WIDTH  operands
- req0_ready / req1_ready  out  1  one-cycle grant pulse; operands accepted when valid&ready
- win_log2  in  5  window exponent w, sampled at grant
- dp_clear  out  1  one-cycle pulse: clear datapath counter and overflow
- dp_run  out  1  datapath enable (LFSR shift, counting)
- dp_op_a, dp_op_b  out  WIDTH  latched operands to comparators
- dp_count  in  CNT_W+1  datapath ones-count
- rsp_valid  out  1  result available
- rsp_id  out  1  requester index of result
- rsp_result  out  WIDTH  scaled result
- rsp_ready  in  1  consumer accepts result
- busy  out  1  state != IDLE

## Operation
- States: IDLE, LOAD, RUN, DRAIN, RESP.
- IDLE: if any reqN_valid, assert grant to one requester (ready pulse that cycle), latch its a/b into dp_op_a/b, latch id, latch w_eff = clamp(win_log2, WIDTH, CNT_W); go LOAD. No valid: stay.
- LOAD: dp_clear=1 for exactly one cycle; go RUN.
- RUN: dp_run=1; internal window counter counts 2^w_eff cycles; on last cycle go DRAIN.
- DRAIN: dp_run stays 1 for PIPE_LAT more cycles so in-flight bits are counted; then dp_run=0, go RESP.
- RESP: sample dp_count once on entry; rsp_result = (dp_count == 2^w_eff) ? all-ones : dp_count >> (w_eff − WIDTH); rsp_valid=1 held with stable data until rsp_ready; on valid&ready go IDLE.
- Arbitration: both valid in IDLE → grant the requester pointed to by prio_ptr; after each grant prio_ptr = ~granted id. Single valid → grant it regardless of pointer.
- Requests during non-IDLE states are ignored (ready stays 0); requester holds valid.
- dp_op_a/b hold their value from grant until next grant.

## Timing
- Reset (rst_n low, any state, asynchronous): state=IDLE, req*_ready=0, dp_clear=0, dp_run=0, dp_op_a/b=0, rsp_valid=0, rsp_id=0, rsp_result=0, busy=0, prio_ptr=0, window counter=0.
- Grant cycle T: req ready=1. T+1: dp_clear=1. T+2 … T+1+2^w: dp_run=1 (RUN). Then PIPE_LAT cycles DRAIN. rsp_valid rises at T+2+2^w+PIPE_LAT.
- Earliest next grant: cycle after rsp handshake (rsp_ready high at first rsp_valid cycle → IDLE next cycle, grant possible that cycle).
- Window counter is w_eff+1 bits wide internally (CNT_W+1 max); no wrap within a window.
- win_log2 changes after grant have no effect on the running job.
- Reset asserted mid-RUN aborts the job; no response is issued; datapath sees dp_run drop asynchronously.

## Configuration
- SN_SCHED_RR_EN defined: round-robin via prio_ptr as above.
- Not defined: fixed priority, requester 0 always wins a tie; prio_ptr logic removed, rsp behaviour otherwise identical.

## Test plan
- Reset mid-RUN with req0 active → all outputs at reset values, no rsp_valid, next req0 granted normally.
- req0 only, a=b=0x1FF, win_log2=9, model count=512 → rsp_result=0x1FF (saturate), rsp_id=0, rsp_valid at grant+2+512+2.
- win_log2=3 (below WIDTH) → clamped to 9: dp_run high exactly 512+PIPE_LAT cycles; win_log2=20 → 2^17 window.
- Both valid continuously, RR enabled → grants alternate 0,1,0,1; RR disabled → always 0 while req0 valid.
- rsp_ready held low 10 cycles → rsp_valid/rsp_result/rsp_id stable, no new grant, busy=1; release → IDLE next cycle.
- dp_count=0x180 with w=10 → rsp_result=0x0C0; check dp_clear is a single pulse the cycle after grant.
